// File: rtl/pio_irq_sequencer.sv
// Avalon-MM master servicing a 4-bit PIO edge-capture interrupt in hardware.
// Events {capture, data} are queued in a small FIFO for a downstream consumer.
module pio_irq_sequencer #(
   parameter logic [3:0] IRQ_MASK_INIT = 4'hF,
   parameter int         FIFO_DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        irq,
   output logic [1:0]  pio_address,
   output logic        pio_chipselect,
   output logic        pio_write_n,
   output logic [31:0] pio_writedata,
   input  logic [31:0] pio_readdata,
   input  logic        cfg_mask_wr,
   input  logic [3:0]  cfg_mask,
   output logic [3:0]  cur_mask,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic [3:0]  evt_capture,
   output logic [3:0]  evt_data,
   output logic [15:0] evt_count,
   output logic        busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

   typedef enum logic [2:0] {
      BOOT, INIT, IDLE, WR_MASK, RD_CAP, RD_DAT, CLR
   } state_t;

   state_t        state;
   logic          mask_pend;
   logic [3:0]    pend_mask;
   logic [3:0]    cap;
   logic [3:0]    dat;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fill;
   logic          full;
   logic          push;
   logic          pop;
   logic          unused_rd;

   assign unused_rd = ^pio_readdata[31:4];

   assign full      = (fill == FULL_CNT);
   assign evt_valid = (fill != '0);
   assign push      = (state == CLR) && (cap != 4'd0);
   assign pop       = evt_valid && evt_ready;
   assign busy      = (state != IDLE);

   assign evt_capture = mem[rd_ptr][7:4];
   assign evt_data    = mem[rd_ptr][3:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= BOOT;
         cur_mask  <= 4'd0;
         mask_pend <= 1'b0;
         pend_mask <= 4'd0;
         cap       <= 4'd0;
         dat       <= 4'd0;
         evt_count <= 16'd0;
      end else begin
         if (cfg_mask_wr) begin
            mask_pend <= 1'b1;
            pend_mask <= cfg_mask;
         end
         unique case (state)
            BOOT: state <= INIT;
            INIT: begin
               cur_mask <= IRQ_MASK_INIT;
               state    <= IDLE;
            end
            IDLE: begin
               if (mask_pend)
                  state <= WR_MASK;
               else if (irq && !full)
                  state <= RD_CAP;
            end
            WR_MASK: begin
               cur_mask <= pend_mask;
               // a request landing now re-arms a second write
               if (!cfg_mask_wr)
                  mask_pend <= 1'b0;
               state <= IDLE;
            end
            RD_CAP: state <= RD_DAT;
            RD_DAT: begin
               cap   <= pio_readdata[3:0];
               state <= CLR;
            end
            CLR: begin
               dat <= pio_readdata[3:0];
               if (cap != 4'd0)
                  evt_count <= evt_count + 16'd1;
               state <= IDLE;
            end
            default: state <= BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   // data half comes straight off the bus: dat only lands after this edge
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {cap, pio_readdata[3:0]};
   end

   always_comb begin
      pio_chipselect = 1'b0;
      pio_write_n    = 1'b1;
      pio_address    = 2'd0;
      pio_writedata  = 32'd0;
      unique case (state)
         INIT: begin
            pio_chipselect = 1'b1;
            pio_write_n    = 1'b0;
            pio_address    = 2'd2;
            pio_writedata  = {28'd0, IRQ_MASK_INIT};
         end
         WR_MASK: begin
            pio_chipselect = 1'b1;
            pio_write_n    = 1'b0;
            pio_address    = 2'd2;
            pio_writedata  = {28'd0, pend_mask};
         end
         RD_CAP: begin
            pio_chipselect = 1'b1;
            pio_address    = 2'd3;
         end
         RD_DAT: begin
            pio_chipselect = 1'b1;
            pio_address    = 2'd0;
         end
         CLR: begin
            if (cap != 4'd0) begin
               pio_chipselect = 1'b1;
               pio_write_n    = 1'b0;
               pio_address    = 2'd3;
               pio_writedata  = {28'd0, cap};
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_pio_irq_sequencer.sv
// Bench for pio_irq_sequencer: behavioural PIO slave, cycle vector table,
// and hand-written sequences for FIFO-full, spurious irq, mask and reset cases.
module tb_pio_irq_sequencer;

   logic        clk;
   logic        reset_n;
   logic        irq;
   logic [1:0]  pio_address;
   logic        pio_chipselect;
   logic        pio_write_n;
   logic [31:0] pio_writedata;
   logic [31:0] pio_readdata;
   logic        cfg_mask_wr;
   logic [3:0]  cfg_mask;
   logic [3:0]  cur_mask;
   logic        evt_valid;
   logic        evt_ready;
   logic [3:0]  evt_capture;
   logic [3:0]  evt_data;
   logic [15:0] evt_count;
   logic        busy;

   int checks = 0;
   int errors = 0;

   pio_irq_sequencer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .irq            (irq),
      .pio_address    (pio_address),
      .pio_chipselect (pio_chipselect),
      .pio_write_n    (pio_write_n),
      .pio_writedata  (pio_writedata),
      .pio_readdata   (pio_readdata),
      .cfg_mask_wr    (cfg_mask_wr),
      .cfg_mask       (cfg_mask),
      .cur_mask       (cur_mask),
      .evt_valid      (evt_valid),
      .evt_ready      (evt_ready),
      .evt_capture    (evt_capture),
      .evt_data       (evt_data),
      .evt_count      (evt_count),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural PIO: any-edge capture, clear wins over a same-cycle edge
   logic [3:0] sw;
   logic [3:0] sw_d;
   logic [3:0] edge_cap;
   logic [3:0] pmask;
   logic       force_irq;
   logic       wr_en;
   logic [3:0] clr_bits;

   assign irq      = (|(edge_cap & pmask)) | force_irq;
   assign wr_en    = pio_chipselect && !pio_write_n;
   assign clr_bits = (wr_en && pio_address == 2'd3) ? pio_writedata[3:0] : 4'd0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sw_d         <= 4'd0;
         edge_cap     <= 4'd0;
         pmask        <= 4'd0;
         pio_readdata <= 32'd0;
      end else begin
         sw_d     <= sw;
         edge_cap <= (edge_cap | (sw ^ sw_d)) & ~clr_bits;
         if (wr_en && pio_address == 2'd2)
            pmask <= pio_writedata[3:0];
         case (pio_address)
            2'd0:    pio_readdata <= {28'd0, sw};
            2'd2:    pio_readdata <= {28'd0, pmask};
            2'd3:    pio_readdata <= {28'd0, edge_cap};
            default: pio_readdata <= 32'd0;
         endcase
      end
   end

   typedef struct {
      logic [3:0]  sw;
      logic        cwr;
      logic [3:0]  cfg;
      logic        rdy;
      logic        cs;
      logic        wn;
      logic [1:0]  addr;
      logic [3:0]  wd;
      logic        bsy;
      logic        vld;
      logic [3:0]  cm;
      logic [15:0] cnt;
      logic [3:0]  ecap;
      logic [3:0]  edat;
   } vec_t;

   vec_t tbl [20];

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_bus(input string nm, input logic cs, input logic wn,
                          input logic [1:0] a, input logic [3:0] wd);
      chk({nm, "_cs"}, {31'd0, pio_chipselect}, {31'd0, cs});
      chk({nm, "_wn"}, {31'd0, pio_write_n}, {31'd0, wn});
      chk({nm, "_addr"}, {30'd0, pio_address}, {30'd0, a});
      chk({nm, "_wd"}, pio_writedata, {28'd0, wd});
   endtask

   task automatic do_reset();
      reset_n     = 1'b0;
      sw          = 4'd0;
      force_irq   = 1'b0;
      cfg_mask_wr = 1'b0;
      cfg_mask    = 4'd0;
      evt_ready   = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      tick();
   endtask

   task automatic toggle(input int b);
      sw[b] = ~sw[b];
      repeat (6) tick();
   endtask

   task automatic pop_chk(input string nm, input logic [3:0] c,
                          input logic [3:0] d);
      chk({nm, "_vld"}, {31'd0, evt_valid}, 32'd1);
      chk({nm, "_cap"}, {28'd0, evt_capture}, {28'd0, c});
      chk({nm, "_dat"}, {28'd0, evt_data}, {28'd0, d});
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // sw cwr cfg rdy | cs wn addr wd bsy vld cm cnt ecap edat
      tbl[0]  = '{4'h0, 0, 4'h0, 0, 0, 1, 2'd0, 4'h0, 1, 0, 4'h0, 16'd0, 4'h0, 4'h0};
      tbl[1]  = '{4'h0, 0, 4'h0, 0, 1, 0, 2'd2, 4'hF, 1, 0, 4'h0, 16'd0, 4'h0, 4'h0};
      tbl[2]  = '{4'h2, 0, 4'h0, 0, 0, 1, 2'd0, 4'h0, 0, 0, 4'hF, 16'd0, 4'h0, 4'h0};
      tbl[3]  = '{4'h2, 0, 4'h0, 0, 0, 1, 2'd0, 4'h0, 0, 0, 4'hF, 16'd0, 4'h0, 4'h0};
      tbl[4]  = '{4'h2, 0, 4'h0, 0, 1, 1, 2'd3, 4'h0, 1, 0, 4'hF, 16'd0, 4'h0, 4'h0};
      tbl[5]  = '{4'h2, 0, 4'h0, 0, 1, 1, 2'd0, 4'h0, 1, 0, 4'hF, 16'd0, 4'h0, 4'h0};
      tbl[6]  = '{4'h2, 0, 4'h0, 0, 1, 0, 2'd3, 4'h2, 1, 0, 4'hF, 16'd0, 4'h0, 4'h0};
      tbl[7]  = '{4'h2, 0, 4'h0, 0, 0, 1, 2'd0, 4'h0, 0, 1, 4'hF, 16'd1, 4'h2, 4'h2};
      tbl[8]  = '{4'h3, 0, 4'h0, 0, 0, 1, 2'd0, 4'h0, 0, 1, 4'hF, 16'd1, 4'h2, 4'h2};
      tbl[9]  = '{4'h3, 0, 4'h0, 0, 0, 1, 2'd0, 4'h0, 0, 1, 4'hF, 16'd1, 4'h2, 4'h2};
      tbl[10] = '{4'h3, 1, 4'h1, 0, 1, 1, 2'd3, 4'h0, 1, 1, 4'hF, 16'd1, 4'h2, 4'h2};
      tbl[11] = '{4'h3, 0, 4'h0, 0, 1, 1, 2'd0, 4'h0, 1, 1, 4'hF, 16'd1, 4'h2, 4'h2};
      tbl[12] = '{4'h3, 0, 4'h0, 0, 1, 0, 2'd3, 4'h1, 1, 1, 4'hF, 16'd1, 4'h2, 4'h2};
      tbl[13] = '{4'h3, 0, 4'h0, 0, 0, 1, 2'd0, 4'h0, 0, 1, 4'hF, 16'd2, 4'h2, 4'h2};
      tbl[14] = '{4'h3, 0, 4'h0, 0, 1, 0, 2'd2, 4'h1, 1, 1, 4'hF, 16'd2, 4'h2, 4'h2};
      tbl[15] = '{4'h3, 0, 4'h0, 1, 0, 1, 2'd0, 4'h0, 0, 1, 4'h1, 16'd2, 4'h2, 4'h2};
      tbl[16] = '{4'h7, 0, 4'h0, 1, 0, 1, 2'd0, 4'h0, 0, 1, 4'h1, 16'd2, 4'h1, 4'h3};
      tbl[17] = '{4'h7, 0, 4'h0, 0, 0, 1, 2'd0, 4'h0, 0, 0, 4'h1, 16'd2, 4'h0, 4'h0};
      tbl[18] = '{4'h7, 0, 4'h0, 0, 0, 1, 2'd0, 4'h0, 0, 0, 4'h1, 16'd2, 4'h0, 4'h0};
      tbl[19] = '{4'h7, 0, 4'h0, 0, 0, 1, 2'd0, 4'h0, 0, 0, 4'h1, 16'd2, 4'h0, 4'h0};

      reset_n     = 1'b0;
      sw          = 4'd0;
      force_irq   = 1'b0;
      cfg_mask_wr = 1'b0;
      cfg_mask    = 4'd0;
      evt_ready   = 1'b0;
      tick();
      tick();
      chk_bus("rst", 1'b0, 1'b1, 2'd0, 4'h0);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_vld", {31'd0, evt_valid}, 32'd0);
      chk("rst_cnt", {16'd0, evt_count}, 32'd0);
      chk("rst_mask", {28'd0, cur_mask}, 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         vec_t v;
         string nm;
         v  = tbl[i];
         nm = $sformatf("row%0d", i);
         chk_bus(nm, v.cs, v.wn, v.addr, v.wd);
         chk({nm, "_busy"}, {31'd0, busy}, {31'd0, v.bsy});
         chk({nm, "_vld"}, {31'd0, evt_valid}, {31'd0, v.vld});
         chk({nm, "_mask"}, {28'd0, cur_mask}, {28'd0, v.cm});
         chk({nm, "_cnt"}, {16'd0, evt_count}, {16'd0, v.cnt});
         if (v.vld) begin
            chk({nm, "_ecap"}, {28'd0, evt_capture}, {28'd0, v.ecap});
            chk({nm, "_edat"}, {28'd0, evt_data}, {28'd0, v.edat});
         end
         sw          = v.sw;
         cfg_mask_wr = v.cwr;
         cfg_mask    = v.cfg;
         evt_ready   = v.rdy;
         tick();
      end
      chk("masked_irq", {31'd0, irq}, 32'd0);

      // FIFO full: fifth irq waits in the PIO, merging later edges
      do_reset();
      toggle(0);
      toggle(1);
      toggle(2);
      toggle(3);
      chk("full_cnt4", {16'd0, evt_count}, 32'd4);
      toggle(0);
      chk("full_irq", {31'd0, irq}, 32'd1);
      chk("full_busy", {31'd0, busy}, 32'd0);
      chk_bus("full_bus", 1'b0, 1'b1, 2'd0, 4'h0);
      chk("full_cnt_hold", {16'd0, evt_count}, 32'd4);
      sw[1] = ~sw[1];
      repeat (3) tick();
      pop_chk("pop1", 4'h1, 4'h1);
      begin
         int n;
         n = 0;
         while (evt_count != 16'd5 && n < 20) begin
            tick();
            n++;
         end
         chk("full_resume_cnt", {16'd0, evt_count}, 32'd5);
      end
      pop_chk("pop2", 4'h2, 4'h3);
      pop_chk("pop3", 4'h4, 4'h7);
      pop_chk("pop4", 4'h8, 4'hF);
      pop_chk("pop5", 4'h3, 4'hC);
      chk("drain_vld", {31'd0, evt_valid}, 32'd0);
      chk("drain_irq", {31'd0, irq}, 32'd0);

      // spurious irq: edge-capture reads back zero
      force_irq = 1'b1;
      tick();
      force_irq = 1'b0;
      chk_bus("sp_rdcap", 1'b1, 1'b1, 2'd3, 4'h0);
      tick();
      chk_bus("sp_rddat", 1'b1, 1'b1, 2'd0, 4'h0);
      tick();
      chk_bus("sp_clr", 1'b0, 1'b1, 2'd0, 4'h0);
      chk("sp_clr_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("sp_busy", {31'd0, busy}, 32'd0);
      chk("sp_cnt", {16'd0, evt_count}, 32'd5);
      chk("sp_vld", {31'd0, evt_valid}, 32'd0);

      // request during WR_MASK triggers a second write
      cfg_mask_wr = 1'b1;
      cfg_mask    = 4'h5;
      tick();
      cfg_mask_wr = 1'b0;
      tick();
      chk_bus("wm1", 1'b1, 1'b0, 2'd2, 4'h5);
      cfg_mask_wr = 1'b1;
      cfg_mask    = 4'h6;
      tick();
      cfg_mask_wr = 1'b0;
      chk("wm1_mask", {28'd0, cur_mask}, 32'h5);
      chk("wm_gap_busy", {31'd0, busy}, 32'd0);
      tick();
      chk_bus("wm2", 1'b1, 1'b0, 2'd2, 4'h6);
      tick();
      chk("wm2_mask", {28'd0, cur_mask}, 32'h6);

      // reset during RD_DAT with two events queued
      do_reset();
      toggle(0);
      toggle(1);
      chk("mid_cnt2", {16'd0, evt_count}, 32'd2);
      sw[2] = ~sw[2];
      repeat (3) tick();
      chk_bus("mid_rddat", 1'b1, 1'b1, 2'd0, 4'h0);
      reset_n = 1'b0;
      sw      = 4'd0;
      #1;
      chk("mid_vld", {31'd0, evt_valid}, 32'd0);
      chk("mid_cnt", {16'd0, evt_count}, 32'd0);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      chk("mid_mask", {28'd0, cur_mask}, 32'd0);
      chk_bus("mid_bus", 1'b0, 1'b1, 2'd0, 4'h0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      chk_bus("mid_init", 1'b1, 1'b0, 2'd2, 4'hF);
      tick();
      chk("mid_mask_f", {28'd0, cur_mask}, 32'hF);
      chk("mid_idle", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
